// File: rtl/rsff_preset_sequencer.sv
// rtl/rsff_preset_sequencer.sv - group-at-a-time async preset/clear sequencer for an RSFF bank
//
// Purpose: loads a requested value into a bank of async set/reset flops by
// pulsing the bank's set_n/rst pins one GROUP of bits at a time. Each pulse is
// held PULSE_CYC cycles and followed by SETTLE_CYC quiet cycles. This bounds how
// many async pins switch at once.
//
// Ports:
//   clk_i     controller clock, rising edge
//   reset_i   asynchronous, active-high reset
//   req_i     start a load (sampled only in IDLE)
//   value_i   target bank value, captured when req_i is accepted
//   abort_i   cancel an in-progress load
//   busy_o    high from the cycle after accept until return to IDLE
//   ack_o     1-cycle pulse when a load completes
//   err_o     1-cycle pulse when a load was aborted
//   set_n_o   per-bit async set to bank, active-low
//   rst_o     per-bit async reset to bank, active-high
module rsff_preset_sequencer #(
  parameter int WIDTH      = 8,
  parameter int GROUP      = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             ack_o,
  output logic             err_o,
  output logic [WIDTH-1:0] set_n_o,
  output logic [WIDTH-1:0] rst_o
);

  localparam int NGRP = (WIDTH + GROUP - 1) / GROUP;
  localparam int GW   = $clog2(NGRP + 1);
  localparam int CMAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_DONE,
    ST_ABORT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] val_q;
  logic [GW-1:0]    grp_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             ack_q;
  logic             err_q;
  logic [WIDTH-1:0] set_n_q;
  logic [WIDTH-1:0] rst_q;

  // The next group to pulse is group 0 of the incoming value when accepting
  // from IDLE, otherwise the group after the current one of the captured value.
  logic [GW-1:0]    grp_d;
  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] hit_d;
  logic [WIDTH-1:0] set_n_d;
  logic [WIDTH-1:0] rst_d;

  assign grp_d = (state_q == ST_IDLE) ? '0 : grp_q + GW'(1);
  assign val_d = (state_q == ST_IDLE) ? value_i : val_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_hit
    localparam int GI = i / GROUP;
    assign hit_d[i] = (grp_d == GW'(GI));
  end

  // set_n and rst are derived from complementary terms of the same bit, so a
  // bit can never be driven to set and reset in the same cycle.
  assign set_n_d = ~(hit_d & val_d);
  assign rst_d   = hit_d & ~val_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      grp_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      set_n_q <= '1;
      rst_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // req takes priority over abort here; abort has no meaning in IDLE.
          if (req_i) begin
            val_q   <= value_i;
            grp_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            set_n_q <= set_n_d;
            rst_q   <= rst_d;
            state_q <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (abort_i || cnt_q == CW'(PULSE_CYC - 1)) begin
            set_n_q <= '1;
            rst_q   <= '0;
            cnt_q   <= '0;
            state_q <= abort_i ? ST_ABORT : ST_SETTLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (abort_i) begin
            cnt_q   <= '0;
            state_q <= ST_ABORT;
          end else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            cnt_q <= '0;
            grp_q <= grp_d;
            if (grp_q == GW'(NGRP - 1)) begin
              ack_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              set_n_q <= set_n_d;
              rst_q   <= rst_d;
              state_q <= ST_PULSE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          // req is deliberately not sampled here; the earliest new accept is
          // the following IDLE cycle.
          state_q <= ST_IDLE;
        end
        ST_ABORT: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          set_n_q <= '1;
          rst_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign set_n_o = set_n_q;
  assign rst_o   = rst_q;

endmodule

// File: tb/tb_rsff_preset_sequencer.sv
// tb/tb_rsff_preset_sequencer.sv - scoreboard bench for rsff_preset_sequencer
module tb_rsff_preset_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic       req8   = 1'b0;
  logic       abort8 = 1'b0;
  logic [7:0] val8   = '0;
  logic       busy8, ack8, err8;
  logic [7:0] setn8, rst8;

  logic       req5   = 1'b0;
  logic       abort5 = 1'b0;
  logic [4:0] val5   = '0;
  logic       busy5, ack5, err5;
  logic [4:0] setn5, rst5;

  logic [7:0] bank8 = 8'h3C;
  logic [4:0] bank5 = 5'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] bank;
    logic [1:0] kind;
    int         t0;
    int         lat;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8, e5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsff_preset_sequencer #(.WIDTH(8), .GROUP(2), .PULSE_CYC(2), .SETTLE_CYC(1)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .req_i(req8), .value_i(val8), .abort_i(abort8),
    .busy_o(busy8), .ack_o(ack8), .err_o(err8), .set_n_o(setn8), .rst_o(rst8)
  );

  rsff_preset_sequencer #(.WIDTH(5), .GROUP(2), .PULSE_CYC(2), .SETTLE_CYC(1)) u_dut5 (
    .clk_i(clk), .reset_i(reset), .req_i(req5), .value_i(val5), .abort_i(abort5),
    .busy_o(busy5), .ack_o(ack5), .err_o(err5), .set_n_o(setn5), .rst_o(rst5)
  );

  // Behavioural async flop banks: reset dominates, active-low set otherwise.
  always @(setn8 or rst8)
    for (int i = 0; i < 8; i++)
      if (rst8[i] === 1'b1) bank8[i] = 1'b0;
      else if (setn8[i] === 1'b0) bank8[i] = 1'b1;

  always @(setn5 or rst5)
    for (int i = 0; i < 5; i++)
      if (rst5[i] === 1'b1) bank5[i] = 1'b0;
      else if (setn5[i] === 1'b0) bank5[i] = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push8(input logic [7:0] b, input logic [1:0] k, input int lat);
    exp_t e;
    e.bank = b; e.kind = k; e.t0 = cyc; e.lat = lat;
    q8.push_back(e);
  endtask

  task automatic push5(input logic [7:0] b, input logic [1:0] k, input int lat);
    exp_t e;
    e.bank = b; e.kind = k; e.t0 = cyc; e.lat = lat;
    q5.push_back(e);
  endtask

  task automatic drain8(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (q8.size() == 0) break;
    end
    check("drain8", 32'(q8.size()), 0);
  endtask

  task automatic drain5(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (q5.size() == 0) break;
    end
    check("drain5", 32'(q5.size()), 0);
  endtask

  // Per-cycle invariants and scoreboard retirement on ack/err.
  always @(negedge clk) begin
    if (!reset) begin
      check("excl8", 32'(~setn8 & rst8), 0);
      check("excl5", 32'(~setn5 & rst5), 0);
      check("ack_err8", 32'(ack8 & err8), 0);
      check("ack_err5", 32'(ack5 & err5), 0);
      if (ack8 || err8) begin
        check("sb8_nonempty", 32'(q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e8 = q8.pop_front();
          check("kind8", 32'({ack8, err8}), 32'(e8.kind));
          check("bank8", 32'(bank8), 32'(e8.bank));
          check("lat8", cyc - e8.t0, e8.lat);
        end
      end
      if (ack5 || err5) begin
        check("sb5_nonempty", 32'(q5.size() != 0), 1);
        if (q5.size() != 0) begin
          e5 = q5.pop_front();
          check("kind5", 32'({ack5, err5}), 32'(e5.kind));
          check("bank5", 32'(bank5), 32'(e5.bank));
          check("lat5", cyc - e5.t0, e5.lat);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 0);
    check("rst_ack", 32'(ack8), 0);
    check("rst_err", 32'(err8), 0);
    check("rst_setn", 32'(setn8), 'hFF);
    check("rst_rst", 32'(rst8), 0);
    check("rst_setn5", 32'(setn5), 'h1F);
    reset = 1'b0;
    @(negedge clk);

    // Full 8-bit load of A5: group pulse patterns and timing.
    req8 = 1'b1; val8 = 8'hA5; push8(8'hA5, 2'b10, 13);
    @(negedge clk); req8 = 1'b0;
    check("t1_busy", 32'(busy8), 1);
    check("t1_setn_g0", 32'(setn8), 'hFE);
    check("t1_rst_g0", 32'(rst8), 'h02);
    @(negedge clk);
    check("t1_setn_hold", 32'(setn8), 'hFE);
    check("t1_rst_hold", 32'(rst8), 'h02);
    @(negedge clk);
    check("t1_settle_setn", 32'(setn8), 'hFF);
    check("t1_settle_rst", 32'(rst8), 0);
    @(negedge clk);
    check("t1_setn_g1", 32'(setn8), 'hFB);
    check("t1_rst_g1", 32'(rst8), 'h08);
    drain8(30);
    @(negedge clk);

    // req held high with value changing: only the first value is written,
    // the second load is accepted in the IDLE cycle after DONE.
    req8 = 1'b1; val8 = 8'h3C; push8(8'h3C, 2'b10, 13);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      val8 = 8'(k * 17);
      if (k == 13) check("t3_done_busy", 32'(busy8), 0);
    end
    @(negedge clk);
    check("t3_idle_busy", 32'(busy8), 0);
    val8 = 8'h5A; push8(8'h5A, 2'b10, 13);
    @(negedge clk); req8 = 1'b0;
    check("t3_busy2", 32'(busy8), 1);
    drain8(30);
    @(negedge clk);

    // Abort in the 2nd pulse cycle of group 1. Group 1 target bits equal the
    // current bank bits, so only group 0 visibly changes.
    req8 = 1'b1; val8 = 8'hA9; push8(8'h59, 2'b01, 7);
    @(negedge clk); req8 = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_g1_setn", 32'(setn8), 'hF7);
    check("t4_g1_rst", 32'(rst8), 'h04);
    @(negedge clk); abort8 = 1'b1;
    @(negedge clk); abort8 = 1'b0;
    check("t4_abort_setn", 32'(setn8), 'hFF);
    check("t4_abort_rst", 32'(rst8), 0);
    check("t4_abort_busy", 32'(busy8), 1);
    drain8(10);
    @(negedge clk); abort8 = 1'b1;
    @(negedge clk); abort8 = 1'b0;
    check("t4_idle_abort_busy", 32'(busy8), 0);
    repeat (3) @(negedge clk);
    check("t4_idle_no_err", 32'(err8), 0);

    // req and abort together in IDLE: req wins.
    req8 = 1'b1; abort8 = 1'b1; val8 = 8'h66; push8(8'h66, 2'b10, 13);
    @(negedge clk); req8 = 1'b0; abort8 = 1'b0;
    drain8(30);
    @(negedge clk);

    // Reset asserted mid-pulse, away from the clock edge.
    req8 = 1'b1; val8 = 8'h0F;
    @(negedge clk); req8 = 1'b0;
    check("t5_setn_g0", 32'(setn8), 'hFC);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_setn", 32'(setn8), 'hFF);
    check("t5_rst_rst", 32'(rst8), 0);
    check("t5_rst_busy", 32'(busy8), 0);
    @(negedge clk);
    check("t5_rst_ack", 32'(ack8), 0);
    check("t5_rst_err", 32'(err8), 0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_post_busy", 32'(busy8), 0);
    req8 = 1'b1; val8 = 8'hC3; push8(8'hC3, 2'b10, 13);
    @(negedge clk); req8 = 1'b0;
    drain8(30);

    // WIDTH=5: partial last group drives only bit 4.
    @(negedge clk);
    req5 = 1'b1; val5 = 5'h1F; push5(8'h1F, 2'b10, 10);
    @(negedge clk); req5 = 1'b0;
    check("t2_setn_g0", 32'(setn5), 'h1C);
    check("t2_rst_g0", 32'(rst5), 0);
    repeat (6) @(negedge clk);
    check("t2_setn_g2", 32'(setn5), 'h0F);
    check("t2_rst_g2", 32'(rst5), 0);
    drain5(30);
    @(negedge clk);
    req5 = 1'b1; val5 = 5'h0A; push5(8'h0A, 2'b10, 10);
    @(negedge clk); req5 = 1'b0;
    check("t2b_setn_g0", 32'(setn5), 'h1D);
    check("t2b_rst_g0", 32'(rst5), 'h01);
    repeat (6) @(negedge clk);
    check("t2b_setn_g2", 32'(setn5), 'h1F);
    check("t2b_rst_g2", 32'(rst5), 'h10);
    drain5(30);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
